csr_req_sequencer: RTL

Synthesizable request sequencer that sits directly upstream of `ibex_cs_registers` and drives its CSR access port. It accepts CSR operations on a valid/ready command channel and buffers them in a command FIFO. It issues at most one operation per cycle to the CSR file, captures the combinational `csr_rdata` and `illegal_csr_insn` results, and returns them in order on a valid/ready response channel. It also keeps saturating issue and illegal-access counters for bring-up and debug.

---
 rtl/csr_req_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/csr_req_sequencer.sv
// Buffers CSR commands, issues at most one per cycle to ibex_cs_registers and
// returns {id, rdata, illegal} in program order, with saturating debug counters.
module csr_req_sequencer #(
  parameter int unsigned CmdDepth = 4,
  parameter int unsigned RspDepth = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [11:0] cmd_addr_i,
  input  logic [1:0]  cmd_op_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic [3:0]  cmd_id_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [3:0]  rsp_id_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_illegal_o,
  output logic        csr_access_o,
  output logic        csr_op_en_o,
  output logic [11:0] csr_addr_o,
  output logic [31:0] csr_wdata_o,
  output logic [1:0]  csr_op_o,
  input  logic [31:0] csr_rdata_i,
  input  logic        illegal_csr_insn_i,
  output logic [15:0] issued_cnt_o,
  output logic [15:0] illegal_cnt_o
);
  localparam int unsigned CAW = $clog2(CmdDepth);
  localparam int unsigned RAW = $clog2(RspDepth);

  typedef struct packed {
    logic [11:0] addr;
    logic [1:0]  op;
    logic [31:0] wdata;
    logic [3:0]  id;
  } cmd_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] rdata;
    logic        illegal;
  } rsp_t;

  cmd_t cmd_mem_q [CmdDepth];
  rsp_t rsp_mem_q [RspDepth];

  logic [CAW:0] cmd_wptr_q, cmd_wptr_d, cmd_rptr_q, cmd_rptr_d;
  logic [RAW:0] rsp_wptr_q, rsp_wptr_d, rsp_rptr_q, rsp_rptr_d;
  logic [15:0]  issued_cnt_q, issued_cnt_d, illegal_cnt_q, illegal_cnt_d;

  logic cmd_empty, cmd_full, rsp_empty, rsp_full;
  logic cmd_push, rsp_pop, issue;
  cmd_t cmd_head, cmd_in;
  rsp_t rsp_head, rsp_in;

  // Pointers carry an extra wrap bit: equal indices with differing wrap bits means full.
  assign cmd_empty = (cmd_wptr_q == cmd_rptr_q);
  assign cmd_full  = (cmd_wptr_q[CAW] != cmd_rptr_q[CAW]) &&
                     (cmd_wptr_q[CAW-1:0] == cmd_rptr_q[CAW-1:0]);
  assign rsp_empty = (rsp_wptr_q == rsp_rptr_q);
  assign rsp_full  = (rsp_wptr_q[RAW] != rsp_rptr_q[RAW]) &&
                     (rsp_wptr_q[RAW-1:0] == rsp_rptr_q[RAW-1:0]);

  assign cmd_ready_o = rst_ni && !cmd_full;
  assign cmd_push    = cmd_valid_i && cmd_ready_o;
  assign rsp_valid_o = rst_ni && !rsp_empty;
  assign rsp_pop     = rsp_valid_o && rsp_ready_i;
  assign issue       = rst_ni && !cmd_empty && (!rsp_full || rsp_pop);

  assign cmd_in   = '{addr: cmd_addr_i, op: cmd_op_i, wdata: cmd_wdata_i, id: cmd_id_i};
  assign cmd_head = cmd_mem_q[cmd_rptr_q[CAW-1:0]];
  assign rsp_in   = '{id: cmd_head.id, rdata: csr_rdata_i, illegal: illegal_csr_insn_i};
  assign rsp_head = rsp_mem_q[rsp_rptr_q[RAW-1:0]];

  // Outputs are forced to zero whenever nothing meaningful is presented, so stale
  // or uninitialised storage never leaks out.
  assign csr_access_o  = issue;
  assign csr_op_en_o   = issue;
  assign csr_addr_o    = issue ? cmd_head.addr  : 12'd0;
  assign csr_wdata_o   = issue ? cmd_head.wdata : 32'd0;
  assign csr_op_o      = issue ? cmd_head.op    : 2'd0;
  assign rsp_id_o      = rsp_valid_o ? rsp_head.id      : 4'd0;
  assign rsp_rdata_o   = rsp_valid_o ? rsp_head.rdata   : 32'd0;
  assign rsp_illegal_o = rsp_valid_o ? rsp_head.illegal : 1'b0;
  assign issued_cnt_o  = issued_cnt_q;
  assign illegal_cnt_o = illegal_cnt_q;

  always_comb begin
    cmd_wptr_d    = cmd_wptr_q;
    cmd_rptr_d    = cmd_rptr_q;
    rsp_wptr_d    = rsp_wptr_q;
    rsp_rptr_d    = rsp_rptr_q;
    issued_cnt_d  = issued_cnt_q;
    illegal_cnt_d = illegal_cnt_q;
    if (cmd_push) cmd_wptr_d = cmd_wptr_q + 1'b1;
    if (rsp_pop)  rsp_rptr_d = rsp_rptr_q + 1'b1;
    if (issue) begin
      cmd_rptr_d = cmd_rptr_q + 1'b1;
      rsp_wptr_d = rsp_wptr_q + 1'b1;
      if (issued_cnt_q != 16'hFFFF) issued_cnt_d = issued_cnt_q + 16'd1;
      if (illegal_csr_insn_i && (illegal_cnt_q != 16'hFFFF)) illegal_cnt_d = illegal_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cmd_wptr_q    <= '0;
      cmd_rptr_q    <= '0;
      rsp_wptr_q    <= '0;
      rsp_rptr_q    <= '0;
      issued_cnt_q  <= '0;
      illegal_cnt_q <= '0;
    end else begin
      cmd_wptr_q    <= cmd_wptr_d;
      cmd_rptr_q    <= cmd_rptr_d;
      rsp_wptr_q    <= rsp_wptr_d;
      rsp_rptr_q    <= rsp_rptr_d;
      issued_cnt_q  <= issued_cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  // Storage needs no reset: entries are only observed between push and pop.
  always_ff @(posedge clk_i) begin
    if (cmd_push) cmd_mem_q[cmd_wptr_q[CAW-1:0]] <= cmd_in;
    if (issue)    rsp_mem_q[rsp_wptr_q[RAW-1:0]] <= rsp_in;
  end
endmodule
